// File: rtl/des_key_if.sv
// Handshake bundle between a DES key-schedule consumer and the scheduler.
// Key and subkey use DES bit numbering: bit 1 is the MSB.
interface des_key_if;
    logic        start;
    logic [1:64] key;
    logic        decrypt;
    logic        abort;
    logic        subkey_ready;
    logic        subkey_valid;
    logic [1:48] subkey;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    modport master (
        output start, key, decrypt, abort, subkey_ready,
        input  subkey_valid, subkey, round, busy, done
    );

    modport slave (
        input  start, key, decrypt, abort, subkey_ready,
        output subkey_valid, subkey, round, busy, done
    );
endinterface

// File: rtl/des_key_scheduler.sv
// DES round-key generator: one 48-bit subkey per handshake, forward or reverse order.
// C/D rotate in place, so decrypt walks the schedule backwards by rotating right.
module des_key_scheduler (
    input  logic     clk,
    input  logic     rst_n,
    des_key_if.slave bus
);
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [1:28] c, d;
    logic [1:56] key_cd;
    logic [3:0]  round;
    logic        dec;
    logic        done;
    logic        accept, hs, last, two;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
        return r;
    endfunction

    function automatic logic [1:28] rot(input logic [1:28] v, input logic right, input logic dbl);
        logic [1:28] r;
        case ({right, dbl})
            2'b00:   r = {v[2:28], v[1]};
            2'b01:   r = {v[3:28], v[1:2]};
            2'b10:   r = {v[28], v[1:27]};
            default: r = {v[27:28], v[1:26]};
        endcase
        return r;
    endfunction

    assign key_cd = pc1(bus.key);
    assign accept = (state == IDLE) && bus.start && !bus.abort;
    assign hs     = (state == RUN) && bus.subkey_ready;
    assign last   = (round == 4'd15);
    // Single-bit rotations fall between emitted rounds 0/7/14 and their successors.
    assign two    = !((round == 4'd0) || (round == 4'd7) || (round == 4'd14));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (bus.abort || (hs && last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.subkey_valid = (state == RUN);
        bus.busy         = (state == RUN);
        bus.round        = round;
        bus.done         = done;
        bus.subkey       = pc2({c, d});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c     <= '0;
            d     <= '0;
            round <= '0;
            dec   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= hs && last && !bus.abort;
            if (accept) begin
                dec   <= bus.decrypt;
                round <= '0;
                // Encrypt starts at C1/D1; decrypt starts at C16/D16, which equal C0/D0.
                c     <= bus.decrypt ? key_cd[1:28]  : rot(key_cd[1:28], 1'b0, 1'b0);
                d     <= bus.decrypt ? key_cd[29:56] : rot(key_cd[29:56], 1'b0, 1'b0);
            end else if (state == RUN) begin
                if (bus.abort || (hs && last)) begin
                    round <= '0;
                end else if (hs) begin
                    round <= round + 4'd1;
                    c     <= rot(c, dec, two);
                    d     <= rot(d, dec, two);
                end
            end
        end
    end
endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: known-answer table, randomized backpressure against
// a cumulative-shift DES schedule model, abort/start/reset corner sequences.
module tb_des_key_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    des_key_if bus ();

    des_key_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

    typedef struct {
        logic [63:0] key;
        bit          dec;
        int          rnd;
        logic [47:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] last_got [16];
    logic [47:0] got_enc [16];
    logic [47:0] got_dec [16];

    // Ki straight from C0/D0 rotated by the cumulative shift count.
    function automatic logic [47:0] model_key(input logic [63:0] k, input int i);
        bit cd0 [56];
        bit cdi [56];
        logic [47:0] r;
        int s = 0;
        for (int j = 0; j < i; j++) s += SHIFTS[j];
        for (int j = 0; j < 56; j++) cd0[j] = k[64 - PC1_T[j]];
        for (int j = 0; j < 28; j++) begin
            cdi[j]      = cd0[(j + s) % 28];
            cdi[28 + j] = cd0[28 + (j + s) % 28];
        end
        for (int m = 0; m < 48; m++) r[47 - m] = cdi[PC2_T[m] - 1];
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_valid"}, 64'(bus.subkey_valid), 64'd0);
        check({nm, "_busy"},  64'(bus.busy), 64'd0);
        check({nm, "_round"}, 64'(bus.round), 64'd0);
        check({nm, "_done"},  64'(bus.done), 64'd0);
    endtask

    // Full schedule from IDLE; called and returns at a negedge.
    task automatic run_sched(input logic [63:0] k, input bit d, input int pct, input bit poke);
        int n = 0;
        int cyc = 0;
        logic [47:0] e;
        logic [47:0] last_exp;
        bus.key = k; bus.decrypt = d; bus.start = 1'b1; bus.subkey_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.key = ~k; bus.decrypt = ~d;
        check("first_valid", 64'(bus.subkey_valid), 64'd1);
        while (n < 16 && cyc < 500) begin
            e = model_key(k, d ? 16 - n : n + 1);
            check("subkey", 64'(bus.subkey), 64'(e));
            check("round",  64'(bus.round), 64'(n));
            check("valid",  64'(bus.subkey_valid), 64'd1);
            last_got[n] = bus.subkey;
            bus.subkey_ready = ($urandom_range(99) < pct);
            bus.start = poke && (n == 3);
            if (bus.subkey_ready) n++;
            @(negedge clk);
            cyc++;
        end
        bus.subkey_ready = 1'b0; bus.start = 1'b0;
        check("handshakes", 64'(n), 64'd16);
        if (pct >= 100) check("burst_cycles", 64'(cyc), 64'd16);
        last_exp = model_key(k, d ? 1 : 16);
        check("done_pulse", 64'(bus.done), 64'd1);
        check("done_valid", 64'(bus.subkey_valid), 64'd0);
        check("done_round", 64'(bus.round), 64'd0);
        check("done_busy",  64'(bus.busy), 64'd0);
        check("cd_retain",  64'(bus.subkey), 64'(last_exp));
        @(negedge clk);
        check("done_once",  64'(bus.done), 64'd0);
        check("cd_retain2", 64'(bus.subkey), 64'(last_exp));
    endtask

    task automatic start_and_walk(input logic [63:0] k, input bit d, input int r);
        int g = 0;
        bus.key = k; bus.decrypt = d; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.round != 4'(r) && g < 40) begin
            bus.subkey_ready = 1'b1;
            @(negedge clk);
            g++;
        end
        check("walk_reached", 64'(bus.round), 64'(r));
    endtask

    task automatic abort_at(input logic [63:0] k, input bit d, input int r);
        start_and_walk(k, d, r);
        bus.abort = 1'b1; bus.subkey_ready = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.subkey_ready = 1'b0;
        check_idle("abort");
        @(negedge clk);
        check("abort_no_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        vec_t vt [4];
        logic [63:0] rk;
        bus.start = 1'b0; bus.key = '0; bus.decrypt = 1'b0;
        bus.abort = 1'b0; bus.subkey_ready = 1'b0;

        vt[0] = '{KAT_KEY, 1'b0, 0,  48'h1B02EFFC7072};
        vt[1] = '{KAT_KEY, 1'b0, 15, 48'hCB3D8B0E17F5};
        vt[2] = '{KAT_KEY, 1'b1, 0,  48'hCB3D8B0E17F5};
        vt[3] = '{KAT_KEY, 1'b1, 15, 48'h1B02EFFC7072};

        #1 rst_n = 1'b0;
        #2;
        check_idle("reset_async");
        check("reset_subkey", 64'(bus.subkey), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        bus.subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.subkey_ready = 1'b0;
        check_idle("ready_idle");

        run_sched(KAT_KEY, 1'b0, 100, 1'b0);
        got_enc = last_got;
        run_sched(KAT_KEY, 1'b1, 100, 1'b0);
        got_dec = last_got;
        for (int i = 0; i < 4; i++)
            check($sformatf("kat%0d", i),
                  64'(vt[i].dec ? got_dec[vt[i].rnd] : got_enc[vt[i].rnd]), 64'(vt[i].exp));
        for (int i = 0; i < 16; i++)
            check("reverse_order", 64'(got_dec[i]), 64'(got_enc[15 - i]));

        for (int t = 0; t < 4; t++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, 1'($urandom_range(1)), 50, (t % 2) == 1);
        end

        abort_at(KAT_KEY, 1'b0, 5);
        run_sched(KAT_KEY, 1'b0, 100, 1'b0);
        abort_at(KAT_KEY, 1'b1, 15);

        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check_idle("start_abort");

        start_and_walk(KAT_KEY, 1'b0, 9);
        #2 rst_n = 1'b0;
        #1;
        check_idle("reset_run");
        check("reset_run_subkey", 64'(bus.subkey), 64'd0);
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_no_done", 64'(bus.done), 64'd0);
        run_sched(KAT_KEY, 1'b1, 50, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
